// File: rtl/tank_bul_arbiter.sv
// Shares one bullet engine among NUM_TANK tanks: latches fire requests, grants them
// round-robin, computes the wrapped spawn cell ahead of the tank and tracks the engine handshake.
module tank_bul_arbiter #(
   parameter int NUM_TANK    = 4,
   parameter int ACK_TIMEOUT = 15,
   parameter int X_MAX       = 24,
   parameter int Y_MAX       = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [NUM_TANK-1:0]   bul_sht,
   input  logic [5*NUM_TANK-1:0] tank_x,
   input  logic [5*NUM_TANK-1:0] tank_y,
   input  logic [2*NUM_TANK-1:0] tank_dir,
   input  logic                  bul_state_feedback,
   output logic                  bul_fire,
   output logic [4:0]            bul_x,
   output logic [4:0]            bul_y,
   output logic [1:0]            bul_dir,
   output logic [2:0]            bul_owner,
   output logic [NUM_TANK-1:0]   pend,
   output logic                  busy,
   output logic                  ack_err
);
   localparam int               CNT_W   = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] ACK_LIM = CNT_W'(ACK_TIMEOUT);
   localparam logic [4:0]       XM      = 5'(X_MAX);
   localparam logic [4:0]       YM      = 5'(Y_MAX);
   localparam logic [2:0]       PTR_RST = 3'(NUM_TANK - 1);

   typedef enum logic [1:0] {S_IDLE, S_FIRE, S_WAIT_ACK, S_FLIGHT} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [NUM_TANK-1:0]   pend_q, pend_d, clr_vec, pend_shift;
   logic [2:0]            last_q, owner_q, gnt_idx;
   logic [4:0]            x_q, y_q, sel_x, sel_y, spawn_x, spawn_y;
   logic [1:0]            dir_q, sel_dir;
   logic                  fire_q, fire_d, err_q, err_d;
   logic                  grant, found, ack_to;
   int                    rot;

   assign grant  = (state_q == S_IDLE) && enable && (pend_q != '0);
   assign ack_to = (state_q == S_WAIT_ACK) && !bul_state_feedback &&
                   ((cnt_q + CNT_W'(1)) == ACK_LIM);

   // Search begins one past the last owner so every tank gets a turn.
   always_comb begin
      gnt_idx    = '0;
      found      = 1'b0;
      rot        = 0;
      pend_shift = '0;
      for (int k = 1; k <= NUM_TANK; k++) begin
         rot        = (int'(last_q) + k) % NUM_TANK;
         pend_shift = pend_q >> rot;
         if (!found && pend_shift[0]) begin
            found   = 1'b1;
            gnt_idx = 3'(rot);
         end
      end
   end

   assign sel_x   = 5'(tank_x   >> (5 * int'(gnt_idx)));
   assign sel_y   = 5'(tank_y   >> (5 * int'(gnt_idx)));
   assign sel_dir = 2'(tank_dir >> (2 * int'(gnt_idx)));

   // Spawn one cell ahead, wrapping the same way tank movement does.
   always_comb begin
      spawn_x = sel_x;
      spawn_y = sel_y;
      case (sel_dir)
         2'b00:   spawn_y = (sel_y == 5'd0) ? YM : sel_y - 5'd1;
         2'b01:   spawn_y = (sel_y == YM) ? 5'd0 : sel_y + 5'd1;
         2'b10:   spawn_x = (sel_x == 5'd0) ? XM : sel_x - 5'd1;
         default: spawn_x = (sel_x == XM) ? 5'd0 : sel_x + 5'd1;
      endcase
   end

   // A new pulse on the grant edge wins over the clear.
   assign clr_vec = grant ? (NUM_TANK'(1) << gnt_idx) : '0;
   assign pend_d  = (pend_q & ~clr_vec) | bul_sht;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (grant) state_d = S_FIRE;
         end
         S_FIRE: begin
            state_d = S_WAIT_ACK;
            cnt_d   = '0;
         end
         S_WAIT_ACK: begin
            if (bul_state_feedback) begin
               state_d = S_FLIGHT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (ack_to) state_d = S_IDLE;
            end
         end
         S_FLIGHT: begin
            if (!bul_state_feedback) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      fire_d = (state_q == S_FIRE);
      err_d  = err_q | ack_to;
      busy   = (state_q != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q  <= '0;
         last_q  <= PTR_RST;
         owner_q <= '0;
         x_q     <= '0;
         y_q     <= '0;
         dir_q   <= '0;
         fire_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         pend_q <= pend_d;
         fire_q <= fire_d;
         err_q  <= err_d;
         if (grant) begin
            last_q  <= gnt_idx;
            owner_q <= gnt_idx;
            x_q     <= spawn_x;
            y_q     <= spawn_y;
            dir_q   <= sel_dir;
         end
      end
   end

   assign bul_fire  = fire_q;
   assign bul_x     = x_q;
   assign bul_y     = y_q;
   assign bul_dir   = dir_q;
   assign bul_owner = owner_q;
   assign pend      = pend_q;
   assign ack_err   = err_q;

endmodule
